// File: rtl/vc_val_rdy_demux_if.sv
// Handshake bundle for vc_val_rdy_demux.
// The master side feeds the input stream and consumes the output streams.
// The slave side is the demux itself.
// Port i of out_msg occupies bits [i*p_nbits +: p_nbits].
interface vc_val_rdy_demux_if #(
  parameter int p_nbits  = 32,
  parameter int p_nports = 4
);

  localparam int c_sbits = $clog2(p_nports);

  logic                        in_val;
  logic                        in_rdy;
  logic [c_sbits-1:0]          in_sel;
  logic [p_nbits-1:0]          in_msg;
  logic [p_nports-1:0]         out_val;
  logic [p_nports-1:0]         out_rdy;
  logic [p_nports*p_nbits-1:0] out_msg;

  // The producer drives the input stream and the per-port ready lines.
  modport master (
    output in_val,
    output in_sel,
    output in_msg,
    output out_rdy,
    input  in_rdy,
    input  out_val,
    input  out_msg
  );

  // The demux accepts the input stream and drives the per-port streams.
  modport slave (
    input  in_val,
    input  in_sel,
    input  in_msg,
    input  out_rdy,
    output in_rdy,
    output out_val,
    output out_msg
  );

endinterface

// File: rtl/vc_val_rdy_demux.sv
// Single-entry buffered val/rdy demultiplexer.
// One message is held in msg_q/sel_q and presented on exactly one output port
// one cycle after it is accepted. When the destination takes it, a new message
// can be captured on the same edge, giving one message per cycle.
// Messages whose select names a port that does not exist are accepted and
// dropped. Both kinds of event are tallied in saturating counters.
// p_nports is expected to be in the range 2..8.
module vc_val_rdy_demux #(
  parameter  int p_nbits  = 32,
  parameter  int p_nports = 4,
  localparam int c_sbits  = $clog2(p_nports),
  localparam int c_cbits  = 16
) (
  input  logic               clk,
  input  logic               reset,
  vc_val_rdy_demux_if.slave  bus,
  output logic [c_cbits-1:0] xfer_count,
  output logic [c_cbits-1:0] drop_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [c_sbits:0]   c_nports = (c_sbits + 1)'(p_nports);
  localparam logic [c_cbits-1:0] c_cmax   = '1;

  state_t              state;
  logic [p_nbits-1:0]  msg_q;
  logic [c_sbits-1:0]  sel_q;
  logic [p_nports-1:0] val_q;

  logic                sel_legal;
  logic [p_nports-1:0] sel_onehot;
  logic                dest_rdy;
  logic                in_rdy;
  logic                in_fire;
  logic                capture;
  logic                xfer_fire;
  logic                drop_fire;

  // Decode the incoming select and pick out the ready of the held message's port.
  always_comb begin
    sel_legal  = ({1'b0, bus.in_sel} < c_nports);
    sel_onehot = '0;
    dest_rdy   = 1'b0;
    for (int i = 0; i < p_nports; i++) begin
      if (bus.in_sel == c_sbits'(i)) begin
        sel_onehot[i] = 1'b1;
      end
      if (sel_q == c_sbits'(i)) begin
        dest_rdy = bus.out_rdy[i];
      end
    end
  end

  // The only combinational ready path: when full, input ready follows the
  // destination's ready so a dequeue and a new capture can share one edge.
  // Nothing is ready while reset is held low.
  assign in_rdy    = reset && ((state == EMPTY) || dest_rdy);
  assign in_fire   = bus.in_val && in_rdy;
  assign capture   = in_fire && sel_legal;
  assign drop_fire = in_fire && !sel_legal;
  assign xfer_fire = reset && (state == FULL) && dest_rdy;

  assign bus.in_rdy  = in_rdy;
  assign bus.out_val = reset ? val_q : '0;
  assign bus.out_msg = {p_nports{msg_q}};

  // Holding register state machine; out_val comes straight from val_q so it
  // never depends on out_rdy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
      msg_q <= '0;
      sel_q <= '0;
      val_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (capture) begin
            state <= FULL;
            msg_q <= bus.in_msg;
            sel_q <= bus.in_sel;
            val_q <= sel_onehot;
          end
        end
        FULL: begin
          if (dest_rdy) begin
            if (capture) begin
              msg_q <= bus.in_msg;
              sel_q <= bus.in_sel;
              val_q <= sel_onehot;
            end else begin
              state <= EMPTY;
              val_q <= '0;
            end
          end
        end
        default: begin
          state <= EMPTY;
          val_q <= '0;
        end
      endcase
    end
  end

  // Saturating delivery and drop counters; both may step on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      xfer_count <= '0;
      drop_count <= '0;
    end else begin
      if (xfer_fire && (xfer_count != c_cmax)) begin
        xfer_count <= xfer_count + 1'b1;
      end
      if (drop_fire && (drop_count != c_cmax)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
